// File: rtl/c3aibadapt_avmm_async_xfer.sv
// rtl/c3aibadapt_avmm_async_xfer.sv - multi-channel SSR capture/update transfer block
// Strobes are synchronised and edge-detected so each SSR pass moves data exactly once.
module c3aibadapt_avmm_async_xfer #(
  parameter int                NUM_CH     = 4,
  parameter int                SYNC_STAGE = 3,
  parameter int                DEBOUNCE   = 4,
  parameter logic [NUM_CH-1:0] DIR_MASK   = {NUM_CH{1'b0}},
  parameter logic [NUM_CH-1:0] RESET_VAL  = {NUM_CH{1'b0}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sr_load,
  input  logic              sr_unload,
  input  logic [NUM_CH-1:0] ssr_data_in,
  input  logic [NUM_CH-1:0] data_in,
  output logic [NUM_CH-1:0] data_out,
  output logic [NUM_CH-1:0] ssr_data_out,
  output logic [NUM_CH-1:0] change_pend,
  output logic              load_done,
  output logic              unload_done
);

  localparam int            CW       = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

  logic [SYNC_STAGE-1:0] load_sync;
  logic [SYNC_STAGE-1:0] unload_sync;
  logic                  load_prev;
  logic                  unload_prev;
  logic                  load_evt;
  logic                  unload_evt;

  assign load_evt   = load_sync[SYNC_STAGE-1] & ~load_prev;
  assign unload_evt = unload_sync[SYNC_STAGE-1] & ~unload_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_sync   <= '0;
      unload_sync <= '0;
      load_prev   <= 1'b0;
      unload_prev <= 1'b0;
      load_done   <= 1'b0;
      unload_done <= 1'b0;
    end else begin
      load_sync   <= {load_sync[SYNC_STAGE-2:0], sr_load};
      unload_sync <= {unload_sync[SYNC_STAGE-2:0], sr_unload};
      load_prev   <= load_sync[SYNC_STAGE-1];
      unload_prev <= unload_sync[SYNC_STAGE-1];
      load_done   <= load_evt;
      unload_done <= unload_evt;
    end
  end

  // Every channel carries both datapaths; DIR_MASK selects which one reaches the outputs.
  logic [NUM_CH-1:0] din_sync [SYNC_STAGE];
  logic [NUM_CH-1:0] din_s;
  logic [NUM_CH-1:0] stable;
  logic [NUM_CH-1:0] snap;
  logic [NUM_CH-1:0] pend;
  logic [NUM_CH-1:0] upd;
  logic [NUM_CH-1:0] accept;
  logic [CW-1:0]     cnt [NUM_CH];

  assign din_s = din_sync[SYNC_STAGE-1];

  always_comb begin
    accept = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      accept[i] = (din_s[i] != stable[i]) && (cnt[i] == CNT_LAST);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGE; s++) din_sync[s] <= RESET_VAL;
      for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
      stable <= RESET_VAL;
      snap   <= RESET_VAL;
      pend   <= '0;
      upd    <= RESET_VAL;
    end else begin
      din_sync[0] <= data_in;
      for (int s = 1; s < SYNC_STAGE; s++) din_sync[s] <= din_sync[s-1];
      for (int i = 0; i < NUM_CH; i++) begin
        if (din_s[i] == stable[i] || accept[i]) cnt[i] <= '0;
        else                                    cnt[i] <= cnt[i] + 1'b1;
      end
      stable <= stable ^ accept;
      if (unload_evt) snap <= stable;
      // A stable-value change on the unload edge must not be lost by the clear.
      pend <= accept | (unload_evt ? '0 : pend);
      if (load_evt) upd <= ssr_data_in;
    end
  end

  assign data_out     = (stable & DIR_MASK) | (upd & ~DIR_MASK);
  assign ssr_data_out = snap & DIR_MASK;
  assign change_pend  = pend & DIR_MASK;

endmodule

// File: tb/tb_c3aibadapt_avmm_async_xfer.sv
// tb/tb_c3aibadapt_avmm_async_xfer.sv - self-checking bench for c3aibadapt_avmm_async_xfer
module tb_c3aibadapt_avmm_async_xfer;
  localparam int         SS  = 3;
  localparam int         DB  = 4;
  localparam logic [3:0] DIR = 4'b0011;
  localparam logic [3:0] RV  = 4'b0100;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sr_load = 1'b0;
  logic       sr_unload = 1'b0;
  logic [3:0] ssr_data_in = 4'b0;
  logic [3:0] data_in = 4'b0;
  logic [3:0] data_out;
  logic [3:0] ssr_data_out;
  logic [3:0] change_pend;
  logic       load_done;
  logic       unload_done;

  c3aibadapt_avmm_async_xfer #(
    .NUM_CH(4), .SYNC_STAGE(SS), .DEBOUNCE(DB), .DIR_MASK(DIR), .RESET_VAL(RV)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .sr_load(sr_load), .sr_unload(sr_unload),
    .ssr_data_in(ssr_data_in), .data_in(data_in), .data_out(data_out),
    .ssr_data_out(ssr_data_out), .change_pend(change_pend),
    .load_done(load_done), .unload_done(unload_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  typedef struct {
    string      name;
    logic       ld;
    logic       ul;
    logic [3:0] ssr;
    logic [3:0] din;
    int         n;
    logic [3:0] e_do;
    logic [3:0] e_sdo;
    logic [3:0] e_pend;
    logic       e_ld;
    logic       e_ud;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(string name, logic ld, logic ul, logic [3:0] ssr, logic [3:0] din,
                              int n, logic [3:0] e_do, logic [3:0] e_sdo, logic [3:0] e_pend,
                              logic e_ld, logic e_ud);
    vec_t v;
    v.name = name; v.ld = ld; v.ul = ul; v.ssr = ssr; v.din = din; v.n = n;
    v.e_do = e_do; v.e_sdo = e_sdo; v.e_pend = e_pend; v.e_ld = e_ld; v.e_ud = e_ud;
    vecs.push_back(v);
  endfunction

  function automatic logic [13:0] outs();
    return {data_out, ssr_data_out, change_pend, load_done, unload_done};
  endfunction

  task automatic check(string name, logic [13:0] got, logic [13:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got do/sdo/pend/ld/ud=%b expected %b", name, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: works on the per-edge input history since reset release.
  bit         ld_h[$];
  bit         ul_h[$];
  logic [3:0] din_h[$];
  logic [3:0] m_stable, m_upd, m_snap, m_pend;
  bit         m_ld, m_ud;

  function automatic bit ld_at(int k);
    return (k < 0) ? 1'b0 : ld_h[k];
  endfunction
  function automatic bit ul_at(int k);
    return (k < 0) ? 1'b0 : ul_h[k];
  endfunction
  function automatic bit din_at(int k, int i);
    return (k < 0) ? RV[i] : din_h[k][i];
  endfunction

  function automatic void model_step(logic [3:0] ssr_now);
    int         n;
    bit         le, ue;
    logic [3:0] acc;
    n   = ld_h.size() - 1;
    le  = ld_at(n - SS) & ~ld_at(n - SS - 1);
    ue  = ul_at(n - SS) & ~ul_at(n - SS - 1);
    acc = '0;
    for (int i = 0; i < 4; i++) begin
      if (DIR[i]) begin
        acc[i] = 1'b1;
        for (int k = 0; k < DB; k++)
          if (din_at(n - SS - k, i) == m_stable[i]) acc[i] = 1'b0;
      end
    end
    if (le) m_upd = ssr_now;
    if (ue) begin
      m_snap = m_stable;
      m_pend = '0;
    end
    m_stable = m_stable ^ acc;
    m_pend   = m_pend | acc;
    m_ld     = le;
    m_ud     = ue;
  endfunction

  function automatic logic [13:0] exp_outs();
    return {(m_stable & DIR) | (m_upd & ~DIR), m_snap & DIR, m_pend & DIR, m_ld, m_ud};
  endfunction

  localparam logic [13:0] RST_OUTS = {RV, 4'b0000, 4'b0000, 1'b0, 1'b0};

  initial begin
    //   name          ld ul ssr      din      n  do       sdo      pend     ld ud
    add("load_pre",    1, 0, 4'b1000, 4'b0000, 3, 4'b0100, 4'b0000, 4'b0000, 0, 0);
    add("load_e3",     1, 0, 4'b1000, 4'b0000, 1, 4'b1000, 4'b0000, 4'b0000, 1, 0);
    add("load_e4",     1, 0, 4'b1000, 4'b0000, 1, 4'b1000, 4'b0000, 4'b0000, 0, 0);
    add("load_hold",   1, 0, 4'b1000, 4'b0000, 5, 4'b1000, 4'b0000, 4'b0000, 0, 0);
    add("load_low",    0, 0, 4'b1000, 4'b0000, 5, 4'b1000, 4'b0000, 4'b0000, 0, 0);
    add("reload_pre",  1, 0, 4'b0100, 4'b0000, 3, 4'b1000, 4'b0000, 4'b0000, 0, 0);
    add("reload_e3",   1, 0, 4'b0100, 4'b0000, 1, 4'b0100, 4'b0000, 4'b0000, 1, 0);
    add("reload_end",  0, 0, 4'b0100, 4'b0000, 1, 4'b0100, 4'b0000, 4'b0000, 0, 0);
    add("short_pulse", 0, 0, 4'b0100, 4'b0001, 3, 4'b0100, 4'b0000, 4'b0000, 0, 0);
    add("short_after", 0, 0, 4'b0100, 4'b0000, 8, 4'b0100, 4'b0000, 4'b0000, 0, 0);
    add("cap_e5",      0, 0, 4'b0100, 4'b0001, 6, 4'b0100, 4'b0000, 4'b0000, 0, 0);
    add("cap_e6",      0, 0, 4'b0100, 4'b0001, 1, 4'b0101, 4'b0000, 4'b0001, 0, 0);
    add("cap_hold",    0, 0, 4'b0100, 4'b0001, 3, 4'b0101, 4'b0000, 4'b0001, 0, 0);
    add("unl_high",    0, 1, 4'b0100, 4'b0001, 2, 4'b0101, 4'b0000, 4'b0001, 0, 0);
    add("unl_e2",      0, 0, 4'b0100, 4'b0001, 1, 4'b0101, 4'b0000, 4'b0001, 0, 0);
    add("unl_e3",      0, 0, 4'b0100, 4'b0001, 1, 4'b0101, 4'b0001, 4'b0000, 0, 1);
    add("unl_e4",      0, 0, 4'b0100, 4'b0001, 1, 4'b0101, 4'b0001, 4'b0000, 0, 0);
    add("align_pre",   0, 0, 4'b0100, 4'b0011, 3, 4'b0101, 4'b0001, 4'b0000, 0, 0);
    add("align_unl",   0, 1, 4'b0100, 4'b0011, 2, 4'b0101, 4'b0001, 4'b0000, 0, 0);
    add("align_e5",    0, 0, 4'b0100, 4'b0011, 1, 4'b0101, 4'b0001, 4'b0000, 0, 0);
    add("align_e6",    0, 0, 4'b0100, 4'b0011, 1, 4'b0111, 4'b0001, 4'b0010, 0, 1);
    add("align_e7",    0, 0, 4'b0100, 4'b0011, 1, 4'b0111, 4'b0001, 4'b0010, 0, 0);
    add("both_pre",    1, 1, 4'b1011, 4'b1111, 3, 4'b0111, 4'b0001, 4'b0010, 0, 0);
    add("both_e3",     1, 1, 4'b1011, 4'b1111, 1, 4'b1011, 4'b0011, 4'b0000, 1, 1);
    add("both_end",    0, 0, 4'b1011, 4'b1111, 1, 4'b1011, 4'b0011, 4'b0000, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    check("in_reset", outs(), RST_OUTS);
    #2 rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      check($sformatf("idle_%0d", c), {12'b0, load_done, unload_done}, 14'b0);
    end
    check("idle_state", outs(), RST_OUTS);

    for (int r = 0; r < vecs.size(); r++) begin
      sr_load     = vecs[r].ld;
      sr_unload   = vecs[r].ul;
      ssr_data_in = vecs[r].ssr;
      data_in     = vecs[r].din;
      repeat (vecs[r].n) @(posedge clk);
      #1;
      check(vecs[r].name, outs(),
            {vecs[r].e_do, vecs[r].e_sdo, vecs[r].e_pend, vecs[r].e_ld, vecs[r].e_ud});
    end

    // Reset mid-debounce (cnt=2 on ch0) with sr_load halfway through its synchroniser.
    data_in = 4'b0010;
    repeat (3) tick();
    sr_load = 1'b1;
    repeat (2) tick();
    check("pre_reset", outs(), {4'b1011, 4'b0011, 4'b0000, 1'b0, 1'b0});
    #2 rst_n = 1'b0;
    #1 check("async_reset", outs(), RST_OUTS);
    sr_load = 1'b0;
    data_in = 4'b0000;
    #2 rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick();
      check($sformatf("post_reset_%0d", c), outs(), RST_OUTS);
    end

    // Randomised run against the history-based model.
    rst_n = 1'b0;
    sr_load = 1'b0; sr_unload = 1'b0; ssr_data_in = '0; data_in = '0;
    #2 rst_n = 1'b1;
    m_stable = RV; m_upd = RV; m_snap = RV; m_pend = '0; m_ld = 1'b0; m_ud = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 4) == 0) sr_load = ~sr_load;
      if ($urandom_range(0, 4) == 0) sr_unload = ~sr_unload;
      if (!sr_load) ssr_data_in = 4'($urandom);
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 5) == 0) data_in[i] = ~data_in[i];
      ld_h.push_back(sr_load);
      ul_h.push_back(sr_unload);
      din_h.push_back(data_in);
      model_step(ssr_data_in);
      tick();
      check($sformatf("rand_%0d", c), outs(), exp_outs());
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/c3aibadapt_avmm_async_xfer.md
Name: c3aibadapt_avmm_async_xfer

Overview:
Parametrised multi-channel async transfer block between the AVMM sideband shift register (SSR) and the adapter reset/config logic, on one oscillator clock. Each channel is statically either capture (local async level -> SSR, with debounce and sticky change flag) or update (SSR data -> local output on load). Load and unload strobes are synchronised and edge-detected, so one SSR pass yields exactly one transfer. It replaces per-bit hand-instantiated capture/update pairs with one configurable block.

Parameters:
NUM_CH, 4, number of channels (>=1)
SYNC_STAGE, 3, synchroniser depth for strobes and capture data (>=2)
DEBOUNCE, 4, consecutive cycles a synchronised capture input must differ from the stable value before it is accepted (>=1)
DIR_MASK, {NUM_CH{1'b0}}, per-channel mode: 1 = capture, 0 = update
RESET_VAL, {NUM_CH{1'b0}}, per-channel reset value of the data path

Ports:
clk  input  1  oscillator clock
rst_n  input  1  asynchronous active-low reset
sr_load  input  1  async SSR load strobe (level, update channels)
sr_unload  input  1  async SSR unload strobe (capture channels)
ssr_data_in  input  NUM_CH  SSR data for update channels; quasi-static while sr_load high
data_in  input  NUM_CH  async local levels for capture channels
data_out  output  NUM_CH  update ch: loaded value; capture ch: debounced stable value
ssr_data_out  output  NUM_CH  capture ch: snapshot taken at unload; update ch: 0
change_pend  output  NUM_CH  capture ch: stable value changed since last unload; update ch: 0
load_done  output  1  one-cycle pulse, update performed
unload_done  output  1  one-cycle pulse, snapshot performed

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low. Assertion clears all state immediately, regardless of clk.
- Reset values:
  - Strobe sync chains and edge registers: 0.
  - Capture sync chains, stable regs, data_out, ssr_data_out (capture bits): RESET_VAL.
  - Debounce counters, change_pend, load_done, unload_done: 0.
  - Update-channel bits of ssr_data_out and change_pend: constant 0.
- Strobe path, same for load and unload:
  - SYNC_STAGE flops, then a prev flop.
  - evt = sync & ~prev.
  - sr_load sampled high at edge E0 -> evt true in the cycle after E(SYNC_STAGE-1) -> action at edge E(SYNC_STAGE); done pulse high for the cycle after E(SYNC_STAGE).
  - Strobe held high: exactly one event. Re-arm requires the synchronised strobe to be low for >=1 cycle.
- Update, DIR_MASK[i]=0:
  - On load evt edge, data_out[i] <= ssr_data_in[i], sampled unsynchronised; environment holds it stable while sr_load is high.
  - data_in[i] is ignored.
- Capture, DIR_MASK[i]=1:
  - data_in[i] goes through SYNC_STAGE flops to give sync[i].
  - Counter width $clog2(DEBOUNCE+1).
  - If sync==stable: cnt<=0.
  - Else if cnt==DEBOUNCE-1: stable<=sync, cnt<=0, change_pend<=1.
  - Else: cnt<=cnt+1.
  - Net effect: an input change sampled at E0 reaches data_out at edge E(SYNC_STAGE+DEBOUNCE-1); pulses shorter than DEBOUNCE clk cycles are dropped.
- Unload evt edge:
  - ssr_data_out[i] <= stable[i] (value before this edge).
  - change_pend[i] <= 0, unless stable[i] updates on the same edge; set wins, so the flag stays 1.
- Simultaneous load and unload events: independent, both execute, both done pulses assert.
- Glitch on a strobe shorter than one clk period: may be missed. Any strobe spanning >=2 clk edges must produce one event.
- No combinational path from any input to any output; all outputs are registered.

Test Plan:
- Config for all tests: NUM_CH=4, SYNC_STAGE=3, DEBOUNCE=4, DIR_MASK=4'b0011, RESET_VAL=4'b0100.
- Reset release -> data_out=4'b0100, ssr_data_out=4'b0000, change_pend=0, no done pulses for 20 cycles with all inputs idle.
- ssr_data_in=4'b1000, sr_load high sampled from E0 and held 10 cycles -> data_out[3:2]=2'b10 from edge E3; load_done high only in the cycle after E3. Drop sr_load for 5 cycles and raise again with ssr_data_in=4'b0100 -> second pulse; data_out[3:2]=2'b01.
- data_in[0]=1 for 3 cycles -> data_out[0] stays 0, change_pend=0. data_in[0]=1 held from E0 -> data_out[0]=1 at E6 and change_pend[0]=1.
- After the previous scenario, pulse sr_unload for 2 cycles -> at E3: ssr_data_out=4'b0001, change_pend=0; unload_done one-cycle pulse.
- Align data_in[1] so stable[1] updates on the unload evt edge -> ssr_data_out[1]=0 (old value), change_pend[1]=1. Raise sr_load and sr_unload on the same edge -> both pulses in the same cycle.
- Assert rst_n mid-debounce (cnt=2) and mid-sync of sr_load -> outputs return to reset values immediately. After release, no stale load_done or stable update occurs.
